// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: the attribute record,
// the default colour key / background, and a log2 helper for derived widths.
package sprite_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int          SPR_FRAMES  = 4;
    localparam int          FRAME_W     = clog2(SPR_FRAMES);
    localparam logic [23:0] KEY_RGB_DEF = 24'hEE35FF;
    localparam logic [23:0] BG_RGB_DEF  = 24'h893892;

    typedef struct packed {
        logic               en;
        logic               flip;
        logic [FRAME_W-1:0] frame;
        logic [9:0]         x;
        logic [9:0]         y;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel, first pipeline stage: bounding-box hit test and ROM
// address generation for the current pixel, registered on pixel_ce.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int CH     = 0,
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int FRAMES = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_ce,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  sprite_attr_t      attr,
    output logic              hit_reg,
    output logic [ADDR_W-1:0] addr_reg
);

    localparam int WX    = clog2(SPR_W);
    localparam int WY    = clog2(SPR_H);
    localparam int WF    = clog2(FRAMES);
    localparam int LOW_W = WF + WY + WX;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CH) << LOW_W;

    logic [10:0]       right_edge;
    logic [10:0]       bottom_edge;
    logic [WX-1:0]     dx;
    logic [WY-1:0]     dy;
    logic [WX-1:0]     sx;
    logic              hit_next;
    logic [ADDR_W-1:0] addr_next;

    // 11-bit edges so a sprite hanging off the right/bottom never wraps to 0
    assign right_edge  = {1'b0, attr.x} + 11'(SPR_W);
    assign bottom_edge = {1'b0, attr.y} + 11'(SPR_H);

    assign hit_next = attr.en
                   && (draw_x >= attr.x) && ({1'b0, draw_x} < right_edge)
                   && (draw_y >= attr.y) && ({1'b0, draw_y} < bottom_edge);

    assign dx = draw_x[WX-1:0] - attr.x[WX-1:0];
    assign dy = draw_y[WY-1:0] - attr.y[WY-1:0];
    // SPR_W-1-sx is a bitwise inversion for a power-of-two width
    assign sx = attr.flip ? ~dx : dx;

    assign addr_next = BASE | ADDR_W'({attr.frame[WF-1:0], dy, sx});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_reg  <= 1'b0;
            addr_reg <= '0;
        end else if (pixel_ce) begin
            hit_reg <= hit_next;
            if (hit_next)
                addr_reg <= addr_next;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: double-buffered attributes, per-channel address
// stage, external ROM stage, then colour-keyed fixed-priority output mux.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          N_SPR   = 4,
    parameter int          SPR_W   = 16,
    parameter int          SPR_H   = 16,
    parameter int          FRAMES  = SPR_FRAMES,
    parameter logic [23:0] KEY_RGB = KEY_RGB_DEF,
    parameter logic [23:0] BG_RGB  = BG_RGB_DEF,
    localparam int         ADDR_W  = clog2(N_SPR * FRAMES * SPR_W * SPR_H),
    localparam int         IDX_W   = (N_SPR > 1) ? clog2(N_SPR) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    pixel_ce,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    blank,
    input  logic                    frame_sync,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  sprite_attr_t            wr_attr,
    output logic [N_SPR*ADDR_W-1:0] rom_addr,
    output logic                    rom_en,
    input  logic [N_SPR*24-1:0]     rom_data,
    output logic [7:0]              Red,
    output logic [7:0]              Green,
    output logic [7:0]              Blue
);

    sprite_attr_t     shadow_reg [N_SPR];
    sprite_attr_t     active_reg [N_SPR];
    logic [N_SPR-1:0] hit_s1;
    logic [N_SPR-1:0] hit_s2_reg;
    logic             blank_s1_reg;
    logic             blank_s2_reg;
    logic [23:0]      rgb_reg;
    logic [23:0]      rgb_next;

    // Commit copies the pre-write shadow, so a same-cycle write waits a frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i)))
                    shadow_reg[i] <= wr_attr;
                if (frame_sync)
                    active_reg[i] <= shadow_reg[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_SPR; gi++) begin : g_chan
            sprite_channel #(
                .CH     (gi),
                .SPR_W  (SPR_W),
                .SPR_H  (SPR_H),
                .FRAMES (FRAMES),
                .ADDR_W (ADDR_W)
            ) u_chan (
                .clk      (Clk),
                .rst_n    (Reset_n),
                .pixel_ce (pixel_ce),
                .draw_x   (DrawX),
                .draw_y   (DrawY),
                .attr     (active_reg[gi]),
                .hit_reg  (hit_s1[gi]),
                .addr_reg (rom_addr[gi*ADDR_W +: ADDR_W])
            );
        end
    endgenerate

    assign rom_en = pixel_ce;

    // hit/blank ride alongside the ROM read so they meet rom_data at the mux
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_s1_reg <= 1'b0;
            blank_s2_reg <= 1'b0;
            hit_s2_reg   <= '0;
            rgb_reg      <= '0;
        end else if (pixel_ce) begin
            blank_s1_reg <= blank;
            blank_s2_reg <= blank_s1_reg;
            hit_s2_reg   <= hit_s1;
            rgb_reg      <= rgb_next;
        end
    end

    // Scan from lowest priority upward so channel 0 overrides everything
    always_comb begin
        rgb_next = BG_RGB;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_s2_reg[i] && (rom_data[i*24 +: 24] != KEY_RGB))
                rgb_next = rom_data[i*24 +: 24];
        end
        if (!blank_s2_reg)
            rgb_next = '0;
    end

    assign Red   = rgb_reg[23:16];
    assign Green = rgb_reg[15:8];
    assign Blue  = rgb_reg[7:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table-driven pixels plus hand sequences, with a
// scoreboard queue aligning expected colours to the 3-strobe pipeline.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam logic [23:0] BG  = 24'h893892;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] P1  = 24'h123456;

    logic         clk;
    logic         Reset_n;
    logic         pixel_ce;
    logic [9:0]   DrawX;
    logic [9:0]   DrawY;
    logic         blank;
    logic         frame_sync;
    logic         wr_en;
    logic [1:0]   wr_idx;
    sprite_attr_t wr_attr;
    logic [47:0]  rom_addr;
    logic         rom_en;
    logic [95:0]  rom_data;
    logic [7:0]   Red, Green, Blue;
    logic [23:0]  rgb;
    logic [23:0]  rom_val [4];

    int errors = 0;
    int checks = 0;
    logic [23:0] sb[$];
    logic [23:0] hold_exp;

    sprite_compositor dut (
        .Clk        (clk),
        .Reset_n    (Reset_n),
        .pixel_ce   (pixel_ce),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .frame_sync (frame_sync),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_attr    (wr_attr),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue)
    );

    assign rgb = {Red, Green, Blue};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ROM model: one enabled-cycle latency, constant colour per channel
    always @(posedge clk)
        if (rom_en)
            for (int i = 0; i < 4; i++) rom_data[i*24 +: 24] <= rom_val[i];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                       input logic [23:0] exp, input int gap);
        logic [23:0] exp_o;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            pixel_ce = 0;
            @(posedge clk);
            #1 chk("hold", {8'h0, rgb}, {8'h0, hold_exp});
        end
        @(negedge clk);
        DrawX = x; DrawY = y; blank = b; pixel_ce = 1;
        sb.push_back(exp);
        @(posedge clk);
        #1 pixel_ce = 0;
        if (sb.size() >= 3) begin
            exp_o = sb.pop_front();
            chk("pixel", {8'h0, rgb}, {8'h0, exp_o});
            hold_exp = exp_o;
        end else begin
            chk("fill", {8'h0, rgb}, 32'h0);
        end
        $display("pix x=%0d y=%0d blank=%0b -> rgb=%h", x, y, b, rgb);
    endtask

    task automatic wr(input int idx, input logic en, input logic flip, input logic [1:0] frame,
                      input logic [9:0] x, input logic [9:0] y, input logic fs);
        @(negedge clk);
        pixel_ce = 0; wr_en = 1; wr_idx = 2'(idx); frame_sync = fs;
        wr_attr = '{en: en, flip: flip, frame: frame, x: x, y: y};
        @(posedge clk);
        #1 wr_en = 0; frame_sync = 0;
        chk("hold_wr", {8'h0, rgb}, {8'h0, hold_exp});
        $display("wr idx=%0d en=%0b flip=%0b frame=%0d x=%0d y=%0d sync=%0b", idx, en, flip, frame, x, y, fs);
    endtask

    task automatic commit();
        @(negedge clk);
        pixel_ce = 0; frame_sync = 1;
        @(posedge clk);
        #1 frame_sync = 0;
        chk("hold_sync", {8'h0, rgb}, {8'h0, hold_exp});
        $display("frame_sync");
    endtask

    task automatic flush(input int gap);
        pix(10'd0, 10'd0, 1'b0, 24'h0, gap);
        pix(10'd0, 10'd0, 1'b0, 24'h0, gap);
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic [23:0] rgb;
        logic [11:0] a0;
        logic [11:0] a1;
    } vec_t;
    vec_t tbl [11];

    initial begin
        // ch0 at (100,50) frame 2; ch1 at (108,52) frame 1
        tbl[0]  = '{x: 103, y: 52, b: 1, rgb: GRN,   a0: 547, a1: 0};
        tbl[1]  = '{x: 99,  y: 52, b: 1, rgb: BG,    a0: 547, a1: 0};
        tbl[2]  = '{x: 115, y: 52, b: 1, rgb: GRN,   a0: 559, a1: 1287};
        tbl[3]  = '{x: 116, y: 52, b: 1, rgb: P1,    a0: 559, a1: 1288};
        tbl[4]  = '{x: 103, y: 66, b: 1, rgb: BG,    a0: 559, a1: 1288};
        tbl[5]  = '{x: 103, y: 65, b: 1, rgb: GRN,   a0: 755, a1: 1288};
        tbl[6]  = '{x: 103, y: 52, b: 0, rgb: 24'h0, a0: 547, a1: 1288};
        tbl[7]  = '{x: 110, y: 60, b: 1, rgb: GRN,   a0: 682, a1: 1410};
        tbl[8]  = '{x: 100, y: 50, b: 1, rgb: GRN,   a0: 512, a1: 1410};
        tbl[9]  = '{x: 123, y: 67, b: 1, rgb: P1,    a0: 512, a1: 1535};
        tbl[10] = '{x: 124, y: 67, b: 1, rgb: BG,    a0: 512, a1: 1535};

        rom_val[0] = GRN; rom_val[1] = P1; rom_val[2] = 24'h0; rom_val[3] = 24'h0;
        Reset_n = 0; pixel_ce = 0; DrawX = 0; DrawY = 0; blank = 0;
        frame_sync = 0; wr_en = 0; wr_idx = 0; wr_attr = '0;
        hold_exp = 24'h0;

        #3;
        chk("reset_rgb", {8'h0, rgb}, 32'h0);
        chk("reset_addr", {31'h0, |rom_addr}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) Reset_n = 1;

        // No sprites: background after the pipeline fills
        for (int k = 0; k < 6; k++) pix(10'(k * 7), 10'd10, 1'b1, BG, 0);

        // Reset mid-frame blacks out immediately, pipeline refills afterwards
        @(negedge clk) Reset_n = 0;
        #1 chk("midrst_rgb", {8'h0, rgb}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) Reset_n = 1;
        sb.delete();
        hold_exp = 24'h0;
        for (int k = 0; k < 4; k++) pix(10'(k * 3), 10'd11, 1'b1, BG, 0);

        wr(0, 1, 0, 2'd2, 10'd100, 10'd50, 0);
        wr(1, 1, 0, 2'd1, 10'd108, 10'd52, 0);
        commit();
        for (int k = 0; k < 11; k++) begin
            pix(tbl[k].x, tbl[k].y, tbl[k].b, tbl[k].rgb, 0);
            chk("addr0", {20'h0, rom_addr[11:0]}, {20'h0, tbl[k].a0});
            chk("addr1", {20'h0, rom_addr[23:12]}, {20'h0, tbl[k].a1});
        end
        flush(0);

        // Colour key on ch0 reveals ch1 beneath, or background
        rom_val[0] = 24'hEE35FF;
        pix(10'd110, 10'd60, 1'b1, P1, 0);
        pix(10'd103, 10'd52, 1'b1, BG, 0);
        pix(10'd116, 10'd52, 1'b1, P1, 0);
        flush(0);
        rom_val[0] = 24'h0000FF;
        pix(10'd110, 10'd60, 1'b1, 24'h0000FF, 0);
        flush(0);
        rom_val[0] = GRN;

        // Right-edge sprite must not wrap onto column 0
        rom_val[2] = 24'hABCDEF;
        wr(2, 1, 0, 2'd0, 10'd1020, 10'd50, 0);
        commit();
        pix(10'd2, 10'd52, 1'b1, BG, 0);
        chk("addr2_nohit", {20'h0, rom_addr[35:24]}, 32'd0);
        pix(10'd1021, 10'd52, 1'b1, 24'hABCDEF, 0);
        chk("addr2", {20'h0, rom_addr[35:24]}, 32'd2081);
        pix(10'd1023, 10'd67, 1'b1, BG, 0);
        pix(10'd1023, 10'd65, 1'b1, 24'hABCDEF, 0);
        chk("addr2_corner", {20'h0, rom_addr[35:24]}, 32'd2291);
        flush(0);

        // Horizontal flip
        wr(0, 1, 1, 2'd2, 10'd100, 10'd50, 0);
        commit();
        pix(10'd103, 10'd52, 1'b1, GRN, 0);
        chk("addr0_flip", {20'h0, rom_addr[11:0]}, 32'd556);

        // Same-cycle write+commit lands in shadow only; pixel_ce every 2nd clock
        wr(0, 1, 1, 2'd2, 10'd200, 10'd50, 1);
        pix(10'd103, 10'd52, 1'b1, GRN, 1);
        chk("addr0_old", {20'h0, rom_addr[11:0]}, 32'd556);
        pix(10'd203, 10'd52, 1'b1, BG, 1);
        commit();
        pix(10'd203, 10'd52, 1'b1, GRN, 1);
        chk("addr0_new", {20'h0, rom_addr[11:0]}, 32'd556);
        pix(10'd103, 10'd52, 1'b1, BG, 1);
        pix(10'd203, 10'd52, 1'b0, 24'h0, 1);
        flush(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
